// File: rtl/ft_pkg.sv
// Shared definitions for the lockstep recovery sequencer: FSM state
// encoding and the debug-bus addresses used to rewrite core state.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_WAIT_HALT,
        ST_WR_GPR,
        ST_WR_NPC,
        ST_RESUME
    } ft_state_e;

    localparam logic [14:0] DBG_GPR_BASE = 15'h0400;
    localparam logic [14:0] DBG_NPC_ADDR = 15'h2000;

    // Debug-bus address of GPR idx: one 32-bit word per register.
    function automatic logic [14:0] gpr_dbg_addr(input logic [4:0] idx);
        return DBG_GPR_BASE + {8'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ft_shadow_rf.sv
// Shadow register file: NUM_GPR x 32 bits, one write port fed by agreed
// lockstep writes, one combinational read port used while replaying the
// GPRs into the cores. x0 is not stored and always reads as zero.
module ft_shadow_rf #(
    parameter int NUM_GPR = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o
);

    localparam int IDX_W = $clog2(NUM_GPR);

    logic [31:0] w_rd [NUM_GPR];

    assign w_rd[0] = '0;

    for (genvar g = 1; g < NUM_GPR; g++) begin : g_reg
        logic [31:0] r_q;

        // One shadow GPR, loaded only by an agreed write to its address.
        // NOTE: every entry has an async reset so a recovery after reset
        // replays a known all-zero state; this rules out a RAM macro.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_q <= '0;
            end else if (we_i && (waddr_i == 5'(g))) begin
                r_q <= wdata_i;
            end
        end

        assign w_rd[g] = r_q;
    end

    assign rdata_o = w_rd[raddr_i[IDX_W-1:0]];

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery sequencer for the dual-core fault-tolerant SoC.
// Compares both cores' regfile write ports every cycle, keeps a shadow RF
// and checkpoint PC from agreeing writes, and on divergence halts both
// cores, rewrites every GPR and the NPC over debug, then resumes them.
// Optional: define FT_ERR_CNT_EN to add the saturating err_cnt_o counter.
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int NUM_GPR = 32
`ifdef FT_ERR_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    output logic        dbg_halt_o,
    output logic        dbg_resume_o,
    input  logic        dbg_halted_a_i,
    input  logic        dbg_halted_b_i,
    output logic        dbg_req_a_o,
    output logic        dbg_req_b_o,
    input  logic        dbg_gnt_a_i,
    input  logic        dbg_gnt_b_i,
    output logic        dbg_we_o,
    output logic [14:0] dbg_addr_o,
    output logic [31:0] dbg_wdata_o,
    output logic        busy_o,
    output logic        recovered_o
`ifdef FT_ERR_CNT_EN
    , output logic [CNT_W-1:0] err_cnt_o
`endif
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_GPR - 1);

    ft_state_e   r_state;
    ft_state_e   w_state_next;
    logic [4:0]  r_idx;
    logic        r_done_a;
    logic        r_done_b;
    logic [31:0] r_ckpt_pc;

    logic        w_mismatch;
    logic        w_agree_we;
    logic        w_in_write;
    logic        w_done_a;
    logic        w_done_b;
    logic        w_both_done;
    logic [31:0] w_shadow_rd;

    assign w_mismatch = (we_a_i != we_b_i) |
                        (we_a_i & we_b_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i)));
    assign w_agree_we = we_a_i & we_b_i & ~w_mismatch & (addr_a_i != 5'd0);

    // A core's write is done once its grant has been sampled with its request up.
    assign w_in_write  = (r_state == ST_WR_GPR) | (r_state == ST_WR_NPC);
    assign w_done_a    = r_done_a | (w_in_write & dbg_gnt_a_i);
    assign w_done_b    = r_done_b | (w_in_write & dbg_gnt_b_i);
    assign w_both_done = w_in_write & w_done_a & w_done_b;

    ft_shadow_rf #(
        .NUM_GPR (NUM_GPR)
    ) u_shadow_rf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (w_agree_we),
        .waddr_i (addr_a_i),
        .wdata_i (data_a_i),
        .raddr_i (r_idx),
        .rdata_o (w_shadow_rd)
    );

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and all debug/status outputs.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        dbg_halt_o   = 1'b0;
        dbg_resume_o = 1'b0;
        dbg_req_a_o  = 1'b0;
        dbg_req_b_o  = 1'b0;
        dbg_we_o     = 1'b0;
        dbg_addr_o   = '0;
        dbg_wdata_o  = '0;
        busy_o       = (r_state != ST_IDLE);
        recovered_o  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_mismatch) w_state_next = ST_HALT;
            end
            ST_HALT: begin
                dbg_halt_o   = 1'b1;
                w_state_next = ST_WAIT_HALT;
            end
            ST_WAIT_HALT: begin
                if (dbg_halted_a_i && dbg_halted_b_i) w_state_next = ST_WR_GPR;
            end
            ST_WR_GPR: begin
                dbg_we_o    = 1'b1;
                dbg_addr_o  = gpr_dbg_addr(r_idx);
                dbg_wdata_o = w_shadow_rd;
                dbg_req_a_o = ~r_done_a;
                dbg_req_b_o = ~r_done_b;
                if (w_both_done && (r_idx == LAST_IDX)) w_state_next = ST_WR_NPC;
            end
            ST_WR_NPC: begin
                dbg_we_o    = 1'b1;
                dbg_addr_o  = DBG_NPC_ADDR;
                dbg_wdata_o = r_ckpt_pc;
                dbg_req_a_o = ~r_done_a;
                dbg_req_b_o = ~r_done_b;
                if (w_both_done) w_state_next = ST_RESUME;
            end
            ST_RESUME: begin
                dbg_resume_o = 1'b1;
                recovered_o  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // GPR index and per-core handshake flags for the debug write sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx    <= 5'd1;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
        end else begin
            if (r_state != ST_WR_GPR) begin
                r_idx <= 5'd1;
            end else if (w_both_done && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 5'd1;
            end

            if (!w_in_write || w_both_done) begin
                r_done_a <= 1'b0;
                r_done_b <= 1'b0;
            end else begin
                r_done_a <= w_done_a;
                r_done_b <= w_done_b;
            end
        end
    end

    // Checkpoint PC tracks core 0 while idle and agreeing; frozen otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ckpt_pc <= '0;
        end else if ((r_state == ST_IDLE) && !w_mismatch) begin
            r_ckpt_pc <= pc_i;
        end
    end

`ifdef FT_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating count of recoveries started (IDLE -> HALT only).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_IDLE) && w_mismatch && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl. A behavioural model keeps the
// agreed architectural state (GPR array and last agreeing PC); each
// recovery is checked against the full debug write sequence each core
// should receive. Define FT_ERR_CNT_EN to also check err_cnt_o (CNT_W=2).
module tb_ft_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b, pc;
    logic        halted_a, halted_b, gnt_a, gnt_b;
    logic        dbg_halt_o, dbg_resume_o, dbg_req_a_o, dbg_req_b_o, dbg_we_o;
    logic [14:0] dbg_addr_o;
    logic [31:0] dbg_wdata_o;
    logic        busy_o, recovered_o;
`ifdef FT_ERR_CNT_EN
    logic [1:0]  err_cnt;
    int          model_err;
`endif

    int n_total = 0;
    int n_fail  = 0;

    logic [31:0] model_rf [32];
    logic [31:0] model_pc;
    logic [47:0] q_a [$];
    logic [47:0] q_b [$];

    ft_recovery_ctrl #(
        .NUM_GPR (32)
`ifdef FT_ERR_CNT_EN
        , .CNT_W (2)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .we_a_i         (we_a),
        .we_b_i         (we_b),
        .addr_a_i       (addr_a),
        .addr_b_i       (addr_b),
        .data_a_i       (data_a),
        .data_b_i       (data_b),
        .pc_i           (pc),
        .dbg_halt_o     (dbg_halt_o),
        .dbg_resume_o   (dbg_resume_o),
        .dbg_halted_a_i (halted_a),
        .dbg_halted_b_i (halted_b),
        .dbg_req_a_o    (dbg_req_a_o),
        .dbg_req_b_o    (dbg_req_b_o),
        .dbg_gnt_a_i    (gnt_a),
        .dbg_gnt_b_i    (gnt_b),
        .dbg_we_o       (dbg_we_o),
        .dbg_addr_o     (dbg_addr_o),
        .dbg_wdata_o    (dbg_wdata_o),
        .busy_o         (busy_o),
        .recovered_o    (recovered_o)
`ifdef FT_ERR_CNT_EN
        , .err_cnt_o    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ctl_vec();
        return 64'({dbg_halt_o, dbg_resume_o, dbg_req_a_o, dbg_req_b_o, dbg_we_o,
                    dbg_addr_o, busy_o, recovered_o});
    endfunction

    // One IDLE cycle of core activity; the model applies the agreement rules.
    task automatic step_idle(input bit wa, input bit wb, input logic [4:0] aa,
                             input logic [4:0] ab, input logic [31:0] da,
                             input logic [31:0] db, input logic [31:0] p);
        bit mm;
        @(negedge clk);
        we_a = wa; we_b = wb; addr_a = aa; addr_b = ab;
        data_a = da; data_b = db; pc = p;
        halted_a = 1'b0; halted_b = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
        mm = (wa != wb) || (wa && wb && ((aa != ab) || (da != db)));
        if (!mm) begin
            model_pc = p;
            if (wa && wb && (aa != 5'd0)) model_rf[aa] = da;
        end
`ifdef FT_ERR_CNT_EN
        else if (model_err < 3) model_err++;
`endif
    endtask

    task automatic random_idle(input int n);
        logic [4:0]  a;
        logic [31:0] d;
        bit          w;
        for (int k = 0; k < n; k++) begin
            a = 5'($urandom_range(31, 0));
            d = $urandom;
            w = 1'($urandom_range(1, 0));
            step_idle(w, w, a, a, d, d, $urandom & 32'hFFFF_FFFC);
        end
    endtask

    // Plays both cores' debug side through one recovery, called right after
    // the mismatch cycle has been driven. Grant latency per write is drawn
    // from [lo, hi]; halted rises hd cycles after the halt pulse.
    task automatic recover(input int ga_lo, input int ga_hi, input int gb_lo, input int gb_hi,
                           input int hd_a, input int hd_b, input bit inject,
                           input bit skew_chk, input int abort_idx, output int busy_cycles);
        logic [47:0] exp_wr [32];
        int  cyc, halts, resumes, recs, both, we_cyc, wa, wb;
        bit  done, timed_out;
        for (int g = 1; g < 32; g++)
            exp_wr[g-1] = {1'b1, 15'(16'h0400 + 16'(4 * g)), model_rf[g]};
        exp_wr[31] = {1'b1, 15'h2000, model_pc};
        q_a.delete(); q_b.delete();
        cyc = 0; halts = 0; resumes = 0; recs = 0; both = 0; we_cyc = 0;
        wa = -1; wb = -1; busy_cycles = 0; done = 1'b0; timed_out = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("halt_next_cycle", 64'(dbg_halt_o), 64'd1);
                check("busy_on_halt", 64'(busy_o), 64'd1);
            end
            if (cyc > 600) begin
                check("recovery_timeout", 64'(busy_o), 64'd0);
                timed_out = 1'b1;
                done = 1'b1;
            end else if (!busy_o) begin
                done = 1'b1;
            end else begin
                busy_cycles++;
                halts   += int'(dbg_halt_o);
                resumes += int'(dbg_resume_o);
                recs    += int'(recovered_o);
                both    += int'(dbg_resume_o & recovered_o);
                we_a = inject && (cyc == 2);
                we_b = 1'b0;
                halted_a = (cyc >= 1 + hd_a);
                halted_b = (cyc >= 1 + hd_b);
                if (abort_idx > 0 && dbg_we_o &&
                    dbg_addr_o == 15'(16'h0400 + 16'(4 * abort_idx))) begin
                    gnt_a = 1'b0; gnt_b = 1'b0; halted_a = 1'b0; halted_b = 1'b0;
                    rst_ni = 1'b0;
                    #1;
                    check("rst_mid_ctl", ctl_vec(), 64'd0);
                    check("rst_mid_wdata", 64'(dbg_wdata_o), 64'd0);
`ifdef FT_ERR_CNT_EN
                    check("rst_mid_errcnt", 64'(err_cnt), 64'd0);
`endif
                    return;
                end
                if (skew_chk && dbg_we_o && we_cyc < 5) begin
                    if (we_cyc < 4) begin
                        check("skew_req_a", 64'(dbg_req_a_o), 64'(we_cyc == 0));
                        check("skew_req_b", 64'(dbg_req_b_o), 64'd1);
                        check("skew_addr", 64'(dbg_addr_o), 64'h404);
                        check("skew_wdata", 64'(dbg_wdata_o), 64'(model_rf[1]));
                    end else begin
                        check("skew_advance", 64'(dbg_addr_o), 64'h408);
                    end
                end
                if (dbg_we_o) we_cyc++;
                if (dbg_req_a_o) begin
                    if (wa < 0) wa = int'($urandom_range(ga_hi, ga_lo));
                    if (wa == 0) begin
                        gnt_a = 1'b1;
                        q_a.push_back({dbg_we_o, dbg_addr_o, dbg_wdata_o});
                        wa = -1;
                    end else begin
                        gnt_a = 1'b0;
                        wa--;
                    end
                end else begin
                    gnt_a = 1'b0;
                    wa = -1;
                end
                if (dbg_req_b_o) begin
                    if (wb < 0) wb = int'($urandom_range(gb_hi, gb_lo));
                    if (wb == 0) begin
                        gnt_b = 1'b1;
                        q_b.push_back({dbg_we_o, dbg_addr_o, dbg_wdata_o});
                        wb = -1;
                    end else begin
                        gnt_b = 1'b0;
                        wb--;
                    end
                end else begin
                    gnt_b = 1'b0;
                    wb = -1;
                end
            end
        end
        gnt_a = 1'b0; gnt_b = 1'b0; halted_a = 1'b0; halted_b = 1'b0;
        we_a = 1'b0; we_b = 1'b0;
        // The first IDLE edge after recovery agrees, so it reloads the checkpoint.
        model_pc = pc;
        if (!timed_out) begin
            check("halt_pulses", 64'(halts), 64'd1);
            check("resume_pulses", 64'(resumes), 64'd1);
            check("recovered_pulses", 64'(recs), 64'd1);
            check("resume_with_recovered", 64'(both), 64'd1);
            check("wr_count_a", 64'(q_a.size()), 64'd32);
            check("wr_count_b", 64'(q_b.size()), 64'd32);
            for (int i = 0; i < 32; i++) begin
                if (i < q_a.size()) check($sformatf("wr_a[%0d]", i), 64'(q_a[i]), 64'(exp_wr[i]));
                if (i < q_b.size()) check($sformatf("wr_b[%0d]", i), 64'(q_b[i]), 64'(exp_wr[i]));
            end
`ifdef FT_ERR_CNT_EN
            check("err_cnt", 64'(err_cnt), 64'(model_err));
`endif
        end
    endtask

    initial begin
        int bc;
        rst_ni = 1'b0;
        we_a = 1'b0; we_b = 1'b0; addr_a = '0; addr_b = '0;
        data_a = '0; data_b = '0; pc = '0;
        halted_a = 1'b0; halted_b = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
        for (int g = 0; g < 32; g++) model_rf[g] = '0;
        model_pc = '0;
`ifdef FT_ERR_CNT_EN
        model_err = 0;
`endif

        // Reset state.
        #22;
        check("reset_ctl", ctl_vec(), 64'd0);
        check("reset_wdata", 64'(dbg_wdata_o), 64'd0);
`ifdef FT_ERR_CNT_EN
        check("reset_errcnt", 64'(err_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_ni = 1'b1;

        // Agreed x5 write, then data divergence on x6.
        step_idle(1, 1, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100);
        step_idle(1, 1, 5'd6, 5'd6, 32'hDEADBEEF, 32'hDEADBEEE, 32'h104);
        recover(0, 1, 0, 2, 0, 0, 1'b0, 1'b0, 0, bc);
        check("x5_gpr_write", 64'(q_a[4]), {16'd0, 1'b1, 15'h414, 32'hDEADBEEF});

        // Write-enable divergence at pc 0x80; NPC is the previous cycle's PC.
        step_idle(1, 1, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 32'h7C);
        step_idle(1, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h80);
        recover(0, 2, 0, 2, 1, 2, 1'b0, 1'b0, 0, bc);
        check("npc_ckpt", 64'(q_a[31]), {16'd0, 1'b1, 15'h2000, 32'h7C});

        // Reset in the middle of the GPR replay (i = 10).
        random_idle(8);
        step_idle(1, 1, 5'd9, 5'd9, 32'h5, 32'h6, 32'h300);
        pc = 32'h400;
        recover(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 10, bc);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int g = 0; g < 32; g++) model_rf[g] = '0;
        model_pc = pc;
`ifdef FT_ERR_CNT_EN
        model_err = 0;
`endif
        @(negedge clk);
        check("idle_after_rst", ctl_vec(), 64'd0);
        // Immediate mismatch: replay must show an all-zero shadow.
        step_idle(0, 1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h404);
        recover(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, bc);

        // Skewed grants: core 0 at once, core 1 three cycles later.
        random_idle(10);
        step_idle(1, 1, 5'd3, 5'd4, 32'hA, 32'hA, 32'h500);
        recover(0, 0, 3, 3, 0, 0, 1'b0, 1'b1, 0, bc);

        // Single-cycle grants and immediate halt: minimum latency.
        random_idle(10);
        step_idle(1, 1, 5'd1, 5'd1, 32'h1, 32'h2, 32'h600);
        recover(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, bc);
        check("busy_cycles_min", 64'(bc), 64'd35);

        // Randomized rounds; the first has a mismatch injected in WAIT_HALT.
        for (int r = 0; r < 3; r++) begin
            logic [4:0]  a;
            logic [31:0] d, p;
            random_idle(25);
            a = 5'($urandom_range(31, 0));
            d = $urandom;
            p = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(2, 0))
                0:       step_idle(1, 0, a, a, d, d, p);
                1:       step_idle(1, 1, a, a ^ 5'd1, d, d, p);
                default: step_idle(1, 1, a, a, d, d ^ 32'h1, p);
            endcase
            recover(0, 3, 0, 3, (r == 0) ? 3 : 2, 4, r == 0, 1'b0, 0, bc);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
